// File: rtl/mem_pkg.sv
// mem_pkg: shared size codes, sequencer states and alignment rule for the load/store unit.
package mem_pkg;
    localparam int ADDR_W_DEF = 8;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR} state_e;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_ILL || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [4:0]  bsh;
    logic [4:0]  hsh;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        bsh = {off, 3'b000};
        hsh = {off[1], 4'b0000};
        b = 8'(word >> bsh);
        h = 16'(word >> hsh);
        ld_data = size == SZ_BYTE ? {{24{sgn & b[7]}}, b} :
                  size == SZ_HALF ? {{16{sgn & h[15]}}, h} : word;
        st_word = size == SZ_BYTE ? (word & ~(32'h0000_00FF << bsh)) | ({24'b0, wdata[7:0]} << bsh) :
                  size == SZ_HALF ? (word & ~(32'h0000_FFFF << hsh)) | ({16'b0, wdata[15:0]} << hsh) : wdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/half/word loads and stores onto a word-wide DataMemory port,
// using read-modify-write for sub-word stores and stalling the pipeline while busy.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              MR,
    output logic              MW,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] WD,
    input  logic [DATA_W-1:0] RD
);
    state_e              state;
    logic [1:0]          r_size;
    logic                r_sgn;
    logic [ADDR_W+1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   ld_data;
    logic [DATA_W-1:0]   st_word;
    logic                unused_addr;

    // High address bits alias onto the same word by design.
    assign unused_addr = &req_addr[31:ADDR_W+2];

    mem_lane_align u_align (
        .word    (RD),
        .wdata   (r_wdata),
        .off     (r_addr[1:0]),
        .size    (r_size),
        .sgn     (r_sgn),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    assign req_ready = state == IDLE;
    assign stall     = req_valid & ~req_ready;
    assign MR        = state == LOAD || state == RMW_RD;
    assign MW        = state == STORE || state == RMW_WR;
    assign Addr      = r_addr[ADDR_W+1:2];
    assign WD        = state == RMW_WR ? merged : state == STORE ? r_wdata : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            r_size    <= '0;
            r_sgn     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            merged    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    r_size  <= req_size;
                    r_sgn   <= req_signed;
                    r_addr  <= req_addr[ADDR_W+1:0];
                    r_wdata <= req_wdata;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        state <= !req_we ? LOAD : req_size == SZ_WORD ? STORE : RMW_RD;
                    end
                end
                LOAD: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ld_data;
                    state     <= IDLE;
                end
                RMW_RD: begin
                    merged <= st_word;
                    state  <= RMW_WR;
                end
                STORE, RMW_WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
